// File: rtl/crossbar_out_resp_pkg.sv
// Shared constants for the PE<->SRAM crossbar pair (request and response sides).
package crossbar_out_resp_pkg;
  localparam int P_MUX_IN    = 4;
  localparam int P_MUX_OUT   = 4;
  localparam int BIT_CONF    = $clog2(P_MUX_IN);
  localparam int P_RD_LAT    = 1;
  localparam int P_CNT_W     = 8;
  localparam int P_STARVE_TH = 64;
  localparam int DATA_W      = 32;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/crossbar_out_resp_if.sv
// Bundle of request/grant inputs and per-PE response outputs of the response crossbar.
interface crossbar_out_resp_if
  import crossbar_out_resp_pkg::*;
#(
  parameter int MUX_IN  = P_MUX_IN,
  parameter int MUX_OUT = P_MUX_OUT
) ();
  logic [MUX_IN-1:0]         rden_i;
  logic [MUX_IN-1:0]         wren_i;
  logic [MUX_OUT*MUX_IN-1:0] peID_i;
  logic [MUX_OUT*DATA_W-1:0] rdata_i;
  logic [MUX_IN-1:0]         gnt_o;
  logic [MUX_IN-1:0]         stall_o;
  logic [MUX_IN-1:0]         rvalid_o;
  logic [MUX_IN*DATA_W-1:0]  rdata_o;
  logic [MUX_IN-1:0]         wack_o;
  logic [MUX_IN-1:0]         starve_o;

  modport slave (
    input  rden_i, wren_i, peID_i, rdata_i,
    output gnt_o, stall_o, rvalid_o, rdata_o, wack_o, starve_o
  );
  modport master (
    output rden_i, wren_i, peID_i, rdata_i,
    input  gnt_o, stall_o, rvalid_o, rdata_o, wack_o, starve_o
  );
endinterface

// File: rtl/crossbar_stall_cnt.sv
// Per-PE consecutive-stall counter, saturating, with registered starvation flag.
module crossbar_stall_cnt
  import crossbar_out_resp_pkg::*;
#(
  parameter int CNT_W     = P_CNT_W,
  parameter int STARVE_TH = P_STARVE_TH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_stall,
  output logic o_starve
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_starve;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_stall) w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  end

  // Flag is derived from the next count so it lines up with the counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_starve <= (32'(w_cnt_nxt) >= 32'(STARVE_TH));
    end
  end

  assign o_starve = r_starve;
endmodule

// File: rtl/crossbar_out_resp.sv
// Response side of the PE/bank crossbar: grant/stall decode, latency-aligned read return,
// write acks and per-PE starvation tracking.
module crossbar_out_resp
  import crossbar_out_resp_pkg::*;
#(
  parameter int MUX_IN    = P_MUX_IN,
  parameter int MUX_OUT   = P_MUX_OUT,
  parameter int RD_LAT    = P_RD_LAT,
  parameter int CNT_W     = P_CNT_W,
  parameter int STARVE_TH = P_STARVE_TH
) (
  input  logic clk_i,
  input  logic rst_i,
  crossbar_out_resp_if.slave bus
);
  localparam int LAST = RD_LAT - 1;

  logic [MUX_IN-1:0]                         w_req, w_gnt, w_stall, w_rd_acc, w_wr_acc;
  logic [MUX_IN-1:0][MUX_OUT-1:0]            w_sel;
  logic [MUX_OUT-1:0][DATA_W-1:0]            w_bank_data;
  logic [MUX_IN-1:0][DATA_W-1:0]             w_rdata;
  logic [MUX_IN-1:0]                         w_starve;
  logic [RD_LAT-1:0][MUX_IN-1:0]             r_vld_pipe;
  logic [RD_LAT-1:0][MUX_IN-1:0][MUX_OUT-1:0] r_sel_pipe;
  logic [MUX_IN-1:0]                         r_wack;

  assign w_bank_data = bus.rdata_i;

  // Transpose per-bank PE selects into per-PE bank selects.
  always_comb begin
    w_sel = '0;
    w_gnt = '0;
    for (int p = 0; p < MUX_IN; p++) begin
      for (int b = 0; b < MUX_OUT; b++) w_sel[p][b] = bus.peID_i[b*MUX_IN+p];
      w_gnt[p] = |w_sel[p];
    end
  end

  assign w_req    = bus.rden_i | bus.wren_i;
  assign w_stall  = w_req & ~w_gnt;
  assign w_rd_acc = w_gnt & bus.rden_i & ~bus.wren_i;
  assign w_wr_acc = w_gnt & bus.wren_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_wack     <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_acc;
      for (int s = 1; s < RD_LAT; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
      r_wack <= w_wr_acc;
    end
  end

  // Bank selects carry no reset; they are only observed through the valid mask.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MUX_IN; p++)
      r_sel_pipe[0][p] <= w_rd_acc[p] ? w_sel[p] : '0;
    for (int s = 1; s < RD_LAT; s++) r_sel_pipe[s] <= r_sel_pipe[s-1];
  end

  for (genvar gp = 0; gp < MUX_IN; gp++) begin : g_pe
    logic [DATA_W-1:0] w_mux;

    always_comb begin
      w_mux = '0;
      for (int b = 0; b < MUX_OUT; b++)
        if (r_sel_pipe[LAST][gp][b]) w_mux |= w_bank_data[b];
    end

    assign w_rdata[gp] = r_vld_pipe[LAST][gp] ? w_mux : '0;

    crossbar_stall_cnt #(
      .CNT_W     (CNT_W),
      .STARVE_TH (STARVE_TH)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_stall  (w_stall[gp]),
      .o_starve (w_starve[gp])
    );
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.stall_o  = w_stall;
  assign bus.rvalid_o = r_vld_pipe[LAST];
  assign bus.rdata_o  = w_rdata;
  assign bus.wack_o   = r_wack;
  assign bus.starve_o = w_starve;
endmodule

// File: tb/tb_crossbar_out_resp.sv
// Drives two instances (read latency 1 and 2) with identical stimulus and checks them against
// a cycle-history reference model plus directed expectations.
module tb_crossbar_out_resp;
  import crossbar_out_resp_pkg::*;

  localparam int NI   = 4;
  localparam int NO   = 4;
  localparam int TH   = 64;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crossbar_out_resp_if ifa ();
  crossbar_out_resp_if ifb ();

  crossbar_out_resp #(.RD_LAT(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  crossbar_out_resp #(.RD_LAT(2)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [NI-1:0]    rd_h  [MAXC];
  logic [NI-1:0]    wr_h  [MAXC];
  logic [NO*NI-1:0] pid_h [MAXC];
  logic             rst_h [MAXC];
  logic [NO*32-1:0] cur_rdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NI-1:0] gnt_of(input logic [NO*NI-1:0] pid);
    logic [NI-1:0] g = '0;
    for (int b = 0; b < NO; b++) g |= pid[b*NI +: NI];
    return g;
  endfunction

  function automatic int bank_of(input logic [NO*NI-1:0] pid, input int p);
    for (int b = 0; b < NO; b++) if (pid[b*NI+p]) return b;
    return 0;
  endfunction

  function automatic logic stalled(input int j, input int p);
    logic [NI-1:0] g = gnt_of(pid_h[j]);
    return (rd_h[j][p] | wr_h[j][p]) & ~g[p];
  endfunction

  // A read granted at cycle k returns in cycle k+L unless reset was high in any cycle k..k+L-1.
  function automatic logic rd_ret(input int L, input int p);
    int k = cyc - L;
    logic [NI-1:0] g;
    if (k < 0) return 1'b0;
    for (int j = k; j < cyc; j++) if (rst_h[j]) return 1'b0;
    g = gnt_of(pid_h[k]);
    return rd_h[k][p] & ~wr_h[k][p] & g[p];
  endfunction

  task automatic check_dut(input string nm, input int L,
                           input logic [NI-1:0] g, input logic [NI-1:0] s,
                           input logic [NI-1:0] rv, input logic [NI-1:0] wk,
                           input logic [NI-1:0] sv, input logic [NI*32-1:0] rdo);
    logic [NI-1:0] eg, es, erv, ewk, esv, gp;
    logic [NI*32-1:0] erd;
    int cnt;
    eg  = gnt_of(pid_h[cyc]);
    es  = (rd_h[cyc] | wr_h[cyc]) & ~eg;
    erv = '0; ewk = '0; esv = '0; erd = '0;
    gp  = (cyc >= 1) ? gnt_of(pid_h[cyc-1]) : '0;
    for (int p = 0; p < NI; p++) begin
      erv[p] = rd_ret(L, p);
      if (erv[p]) erd[p*32 +: 32] = cur_rdat[bank_of(pid_h[cyc-L], p)*32 +: 32];
      ewk[p] = (cyc >= 1) && !rst_h[cyc-1] && wr_h[cyc-1][p] && gp[p];
      cnt = 0;
      for (int j = cyc - 1; j >= 0 && cnt < 300; j--) begin
        if (rst_h[j] || !stalled(j, p)) break;
        cnt++;
      end
      esv[p] = ((cnt > 255) ? 255 : cnt) >= TH;
    end
    chk({nm, "_gnt"},    32'(g),  32'(eg));
    chk({nm, "_stall"},  32'(s),  32'(es));
    chk({nm, "_rvalid"}, 32'(rv), 32'(erv));
    chk({nm, "_wack"},   32'(wk), 32'(ewk));
    chk({nm, "_starve"}, 32'(sv), 32'(esv));
    for (int p = 0; p < NI; p++) chk({nm, "_rdata"}, rdo[p*32 +: 32], erd[p*32 +: 32]);
  endtask

  // Drive one cycle's inputs, then check both instances on the falling edge.
  task automatic step(input logic r, input logic [NI-1:0] rd, input logic [NI-1:0] wr,
                      input logic [NO*NI-1:0] pid, input logic [NO*32-1:0] rdat);
    int nb;
    for (int b = 0; b < NO; b++)
      assert ($countones(pid[b*NI +: NI]) <= 1) else $error("bank %0d select not one-hot", b);
    for (int p = 0; p < NI; p++) begin
      nb = 0;
      for (int b = 0; b < NO; b++) nb += int'(pid[b*NI+p]);
      assert (nb <= 1) else $error("PE %0d granted on several banks", p);
    end
    rst = r;
    ifa.rden_i = rd;  ifa.wren_i = wr;  ifa.peID_i = pid;  ifa.rdata_i = rdat;
    ifb.rden_i = rd;  ifb.wren_i = wr;  ifb.peID_i = pid;  ifb.rdata_i = rdat;
    rd_h[cyc] = rd;  wr_h[cyc] = wr;  pid_h[cyc] = pid;  rst_h[cyc] = r;
    cur_rdat = rdat;
    @(negedge clk);
    check_dut("a", 1, ifa.gnt_o, ifa.stall_o, ifa.rvalid_o, ifa.wack_o, ifa.starve_o, ifa.rdata_o);
    check_dut("b", 2, ifb.gnt_o, ifb.stall_o, ifb.rvalid_o, ifb.wack_o, ifb.starve_o, ifb.rdata_o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cyc < MAXC - 1) cyc++;
  endtask

  task automatic cycle(input logic r, input logic [NI-1:0] rd, input logic [NI-1:0] wr,
                       input logic [NO*NI-1:0] pid, input logic [NO*32-1:0] rdat);
    step(r, rd, wr, pid, rdat);
    tick();
  endtask

  function automatic logic [NO*32-1:0] rnd_data();
    logic [NO*32-1:0] d;
    for (int b = 0; b < NO; b++) d[b*32 +: 32] = $urandom;
    return d;
  endfunction

  // Fixed-priority request crossbar: lowest-numbered requesting PE wins each bank.
  function automatic logic [NO*NI-1:0] arb(input logic [NI-1:0] req, input logic [NI-1:0][1:0] tgt);
    logic [NO*NI-1:0] pid = '0;
    for (int b = 0; b < NO; b++)
      for (int p = 0; p < NI; p++)
        if (req[p] && int'(tgt[p]) == b && pid[b*NI +: NI] == '0) pid[b*NI+p] = 1'b1;
    return pid;
  endfunction

  logic [NO*32-1:0]      rdat;
  logic [NI-1:0]         rd, wr;
  logic [NI-1:0][1:0]    tgt;

  initial begin
    rst = 1'b1;
    ifa.rden_i = '0; ifa.wren_i = '0; ifa.peID_i = '0; ifa.rdata_i = '0;
    ifb.rden_i = '0; ifb.wren_i = '0; ifb.peID_i = '0; ifb.rdata_i = '0;
    @(posedge clk);
    #1;

    cycle(1'b1, '0, '0, '0, rnd_data());
    step(1'b0, '0, '0, '0, rnd_data());
    chk("rst_rvalid", 32'(ifa.rvalid_o), 32'h0);
    chk("rst_starve", 32'(ifb.starve_o), 32'h0);
    tick();

    // Single read: PE1 on bank 2.
    step(1'b0, 4'b0010, '0, 16'h0200, rnd_data());
    chk("single_gnt", 32'(ifa.gnt_o), 32'h2);
    tick();
    rdat = rnd_data();
    rdat[64 +: 32] = 32'hDEADBEEF;
    step(1'b0, '0, '0, '0, rdat);
    chk("single_rv", 32'(ifa.rvalid_o), 32'h2);
    chk("single_rd", ifa.rdata_o[32 +: 32], 32'hDEADBEEF);
    tick();
    cycle(1'b0, '0, '0, '0, rnd_data());

    // Conflict: PE0 and PE3 both on bank 0.
    step(1'b0, 4'b1001, '0, 16'h0001, rnd_data());
    chk("conf_gnt",   32'(ifa.gnt_o),   32'h1);
    chk("conf_stall", 32'(ifa.stall_o), 32'h8);
    tick();
    step(1'b0, '0, '0, '0, rnd_data());
    chk("conf_rv", 32'(ifa.rvalid_o), 32'h1);
    tick();

    // Parallel: PE p reads bank 3-p, bank b returns value b.
    cycle(1'b0, 4'b1111, '0, 16'h1248, rnd_data());
    step(1'b0, '0, '0, '0, {32'h3, 32'h2, 32'h1, 32'h0});
    for (int p = 0; p < NI; p++) chk("par_rd", ifa.rdata_o[p*32 +: 32], 32'(3 - p));
    tick();

    // Back-to-back writes: PE2 on bank 1.
    cycle(1'b0, '0, 4'b0100, 16'h0040, rnd_data());
    step(1'b0, '0, 4'b0100, 16'h0040, rnd_data());
    chk("wack_1", 32'(ifa.wack_o), 32'h4);
    tick();
    step(1'b0, '0, '0, '0, rnd_data());
    chk("wack_2", 32'(ifa.wack_o), 32'h4);
    chk("wack_norv", 32'(ifa.rvalid_o), 32'h0);
    tick();
    step(1'b0, '0, '0, '0, rnd_data());
    chk("wack_off", 32'(ifa.wack_o), 32'h0);
    tick();

    // Starvation of PE3 behind PE0 on bank 0, run past counter saturation.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 4'b1001, '0, 16'h0001, rnd_data());
      if (i == 63)  chk("starve_lo",  32'(ifa.starve_o), 32'h0);
      if (i == 64)  chk("starve_hi",  32'(ifa.starve_o), 32'h8);
      if (i == 299) chk("starve_sat", 32'(ifb.starve_o), 32'h8);
      tick();
    end
    cycle(1'b0, 4'b1000, '0, 16'h0008, rnd_data());
    step(1'b0, '0, '0, '0, rnd_data());
    chk("starve_clr", 32'(ifa.starve_o), 32'h0);
    tick();

    // Reset while a latency-2 read is in flight.
    cycle(1'b0, 4'b0001, '0, 16'h0001, rnd_data());
    cycle(1'b1, '0, '0, '0, rnd_data());
    step(1'b0, '0, '0, '0, rnd_data());
    chk("rstf_rv",   32'(ifb.rvalid_o), 32'h0);
    chk("rstf_rd",   ifb.rdata_o[31:0], 32'h0);
    chk("rstf_wack", 32'(ifb.wack_o),   32'h0);
    tick();
    step(1'b0, '0, '0, '0, rnd_data());
    chk("rstf_rv2", 32'(ifb.rvalid_o), 32'h0);
    tick();

    // Random traffic through the fixed-priority arbiter, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < NI; p++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: begin rd[p] = 1'b1; wr[p] = 1'b0; end
          3, 4:    begin rd[p] = 1'b0; wr[p] = 1'b1; end
          5:       begin rd[p] = 1'b1; wr[p] = 1'b1; end
          default: begin rd[p] = 1'b0; wr[p] = 1'b0; end
        endcase
      end
      tgt = NI*2'($urandom);
      cycle($urandom_range(0, 99) == 0, rd, wr, arb(rd | wr, tgt), rnd_data());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
